// File: rtl/hal_2.sv
// hal_2: switch-driven register-file execution unit with debounced launch key,
// iterative multiplier, hardwired-zero r0 and hex display of results/registers.
module hal_2 #(
   parameter int WIDTH = 16,
   parameter int AW    = 4,
   parameter int NDIG  = WIDTH / 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key0,
   input  logic              key3,
   input  logic [3:0]        sw_op,
   input  logic [AW-1:0]     sw_a,
   input  logic [AW-1:0]     sw_b,
   input  logic [AW-1:0]     sw_c,
   output logic [13:0]       hex_rb,
   output logic [13:0]       hex_rc,
   output logic [7*NDIG-1:0] hex_res,
   output logic              busy,
   output logic              ovf
);
   localparam int NREGS = 2 ** AW;
   localparam int MSB   = WIDTH - 1;
   localparam int CW    = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_SLT  = 4'h6;
   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_LI   = 4'h8;
   localparam logic [3:0] OP_MUL  = 4'h9;
   localparam logic [3:0] OP_SLL  = 4'hA;
   localparam logic [3:0] OP_SRL  = 4'hB;

   typedef enum logic {IDLE, MUL} state_t;

   state_t               state;
   logic [WIDTH-1:0]     regs [NREGS];
   logic [WIDTH-1:0]     result_reg;
   logic                 k0_s1, k0_s2;
   logic                 k3_s1, k3_s2, k3_s3;
   logic                 go;
   logic [WIDTH-1:0]     rs_val, rt_val, view_val, imm, disp;
   logic [WIDTH-1:0]     add_res, sub_res, addi_res, alu_res;
   logic [31:0]          shamt;
   logic                 alu_ovf, alu_commit;
   logic [2*WIDTH-1:0]   mul_mcand, mul_acc, acc_next;
   logic [WIDTH-1:0]     mul_mplier;
   logic [AW-1:0]        mul_rd;
   logic [CW-1:0]        mul_cnt;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   assign go       = k3_s2 & ~k3_s3;
   assign rs_val   = (sw_b == '0) ? '0 : regs[sw_b];
   assign rt_val   = (sw_c == '0) ? '0 : regs[sw_c];
   assign view_val = (sw_a == '0) ? '0 : regs[sw_a];
   assign imm      = WIDTH'(sw_c);
   assign acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

   // Single-cycle ALU; alu_commit marks opcodes that write rd/result/ovf.
   always_comb begin
      add_res    = rs_val + rt_val;
      sub_res    = rs_val - rt_val;
      addi_res   = rs_val + imm;
      shamt      = 32'(sw_c) % 32'(WIDTH);
      alu_res    = '0;
      alu_ovf    = 1'b0;
      alu_commit = 1'b1;
      case (sw_op)
         OP_ADD: begin
            alu_res = add_res;
            alu_ovf = (rs_val[MSB] == rt_val[MSB]) && (add_res[MSB] != rs_val[MSB]);
         end
         OP_SUB: begin
            alu_res = sub_res;
            alu_ovf = (rs_val[MSB] != rt_val[MSB]) && (sub_res[MSB] != rs_val[MSB]);
         end
         OP_AND:  alu_res = rs_val & rt_val;
         OP_OR:   alu_res = rs_val | rt_val;
         OP_XOR:  alu_res = rs_val ^ rt_val;
         OP_SLT:  alu_res = WIDTH'($signed(rs_val) < $signed(rt_val));
         OP_ADDI: begin
            alu_res = addi_res;
            alu_ovf = (rs_val[MSB] == imm[MSB]) && (addi_res[MSB] != rs_val[MSB]);
         end
         OP_LI:   alu_res = imm;
         OP_SLL:  alu_res = rs_val << shamt;
         OP_SRL:  alu_res = rs_val >> shamt;
         default: alu_commit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         ovf        <= 1'b0;
         result_reg <= '0;
         k0_s1      <= 1'b0;
         k0_s2      <= 1'b0;
         k3_s1      <= 1'b0;
         k3_s2      <= 1'b0;
         k3_s3      <= 1'b0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
         mul_acc    <= '0;
         mul_rd     <= '0;
         mul_cnt    <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         k0_s1 <= ~key0;
         k0_s2 <= k0_s1;
         k3_s1 <= ~key3;
         k3_s2 <= k3_s1;
         k3_s3 <= k3_s2;
         case (state)
            IDLE: begin
               if (go && sw_op == OP_MUL) begin
                  mul_mcand  <= {{WIDTH{1'b0}}, rs_val};
                  mul_mplier <= rt_val;
                  mul_acc    <= '0;
                  mul_rd     <= sw_a;
                  mul_cnt    <= '0;
                  busy       <= 1'b1;
                  state      <= MUL;
               end else if (go && alu_commit) begin
                  if (sw_a != '0) regs[sw_a] <= alu_res;
                  result_reg <= alu_res;
                  ovf        <= alu_ovf;
               end
            end
            MUL: begin
               // Shift-add step; the last step commits acc_next directly.
               mul_acc    <= acc_next;
               mul_mcand  <= mul_mcand << 1;
               mul_mplier <= mul_mplier >> 1;
               mul_cnt    <= mul_cnt + 1'b1;
               if (mul_cnt == CW'(WIDTH - 1)) begin
                  if (mul_rd != '0) regs[mul_rd] <= acc_next[WIDTH-1:0];
                  result_reg <= acc_next[WIDTH-1:0];
                  ovf        <= |acc_next[2*WIDTH-1:WIDTH];
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      disp    = k0_s2 ? view_val : result_reg;
      hex_rb  = {seg7(rs_val[7:4]), seg7(rs_val[3:0])};
      hex_rc  = {seg7(rt_val[7:4]), seg7(rt_val[3:0])};
      hex_res = '0;
      for (int i = 0; i < NDIG; i++) hex_res[7*i +: 7] = seg7(disp[4*i +: 4]);
   end
endmodule

// File: doc/hal_2.md
Name: hal_2

Overview:
- Parametrised successor to the board-level execution unit.
- Register file of NREGS x WIDTH, driven from board switches. Operations are launched by a debounced, edge-detected push key.
- Adds a multi-cycle iterative multiply with busy/overflow status, a hardwired-zero r0, and a register-view mode.
- Sits directly under the board top. Keys and switches come in raw; 7-segment buses go out.

Parameters:
- WIDTH, 16: register/ALU width in bits. Must be a multiple of 4 and ≥ 8.
- AW, 4: register address width. NREGS = 2**AW.
- NDIG, WIDTH/4: number of result hex digits (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- key0  in  1  raw push key, active-low. While held, the result display shows register sw_a.
- key3  in  1  raw push key, active-low. Press launches the operation.
- sw_op  in  4  opcode.
- sw_a  in  AW  destination register rd.
- sw_b  in  AW  source register rs.
- sw_c  in  AW  source register rt, or immediate imm (zero-extended).
- hex_rb  out  14  two digits: low byte of reg[sw_b].
- hex_rc  out  14  two digits: low byte of reg[sw_c].
- hex_res  out  7*NDIG  result digits, most-significant digit in the top 7 bits.
- busy  out  1  multiply in progress.
- ovf  out  1  overflow flag of the last committed op.

Behaviour:
- Reset (async, rst=1): all registers 0, result_reg 0, busy 0, ovf 0, FSM IDLE, synchronizer flops 0.
- Reset mid-multiply aborts the multiply with no writeback.
- 7-seg encoding: active-low, bit order gfedcba, hex digits 0-F.
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000.
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- Key path (per key):
  - Sample ~key into s1, then s2, then s3.
  - go = s2 & ~s3: exactly one cycle per press, however long the key is held.
- Timing: edge 1 samples key3 low; go is high after edge 2; a single-cycle op commits on edge 3.
- r0 always reads 0. Writes to r0 are dropped, but result_reg and ovf still update.
- Opcodes:
  - 0 NOP: no writes.
  - 1 ADD: rd = rs + rt.
  - 2 SUB: rd = rs − rt.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SLT: signed compare, result 1 or 0.
  - 7 ADDI: rd = rs + imm.
  - 8 LI: rd = imm.
  - 9 MUL: low WIDTH bits of rs*rt, unsigned, iterative.
  - A SLL: rd = rs << imm.
  - B SRL: rd = rs >> imm. Shift amount is imm mod WIDTH.
  - C-F: treated as NOP.
- Each committing op writes rd and result_reg on the same edge.
- ovf rules:
  - ovf = signed overflow for ADD/SUB/ADDI.
  - ovf = (high WIDTH bits of the product ≠ 0) for MUL.
  - ovf = 0 for all other ops except NOP, which leaves ovf unchanged.
- FSM IDLE / MUL:
  - IDLE: go & op≠9 → commit, stay in IDLE.
  - IDLE: go & op=9 → latch rs, rt and rd, clear accumulator, busy=1, go to MUL.
  - MUL: one shift-add step per clock for WIDTH clocks.
  - On the WIDTH-th MUL edge: commit, busy=0, return to IDLE.
  - MUL commit therefore lands on edge 3 + WIDTH, counted from the first edge that sampled key3 low.
- go while busy=1 is ignored: not queued, no state change.
- Switch changes during MUL have no effect, because operands are latched at entry.
- Display:
  - hex_res shows result_reg. While key0 is held (s2 of key0 = 1) it shows reg[sw_a] instead.
  - hex_rb and hex_rc are combinational from the current register contents, updated on the edge after a write.

Test Plan (WIDTH=16, AW=4):
1. Reset, then LI r3,5; LI r2,9; ADD r4=r3+r2 (op 1, a=4, b=3, c=2), each with a 1-cycle key3 pulse:
   - r4=0x000E, committed on edge 3 after the press; hex_res = 1000000,1000000,1000000,0000110; ovf=0.
2. LI r1,0xF; SLL r1=r1<<15 (r1=0x8000); SUB r5=r1−r4:
   - 0x8000−0x000E gives r5=0x7FF2, ovf=1.
   - A following AND clears ovf to 0.
3. MUL r6=r2*r3 (9*5):
   - busy rises on edge 3 and stays high for exactly 16 clocks.
   - r6=0x002D appears on edge 19; ovf=0.
   - A second key3 press mid-multiply is ignored: no extra commit, busy length unchanged.
4. key3 held low for 50 cycles:
   - exactly one commit, e.g. ADDI r7=r7+1 gives r7=1, not 50.
5. LI r0,7, then hold key0 with sw_a=0:
   - hex_res shows 0000; hex_rb with sw_b=0 shows 1000000,1000000.
6. Start MUL with 0xFFFF*0x0002, assert rst on cycle 8 of MUL:
   - busy=0 immediately, rd stays 0, all registers 0.
   - Rerun after reset: result 0xFFFE, ovf=1.
